lsq_param_fwd: RTL and testbench

//   Parametrised load/store queue between RS_mem/FU_mem, the ROB and data memory. Allocates loads and stores in

---
 rtl/lsq_param_fwd.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_lsq_param_fwd.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsq_param_fwd.sv
`default_nettype none
// ============================================================================
// Module   : lsq_param_fwd
// Purpose  : Parametrised load/store queue. Allocates loads and stores in
//            program order at dispatch, captures address/data at issue,
//            forwards byte-accurate store data to younger loads, and drains
//            committed stores to memory through a valid/ready write port.
// Ports    : clk, reset (async, active-low)
//            disp_*   : in-order allocation at tail (disp_ready = room)
//            iss_*    : address/data capture for a dispatched tag
//            ld_*     : combinational store-to-load forwarding lookup
//            commit_* : ROB retirement of the head entry
//            mem_wr_* : registered store write port (valid/ready)
//            flush    : squash all uncommitted entries
//            count / empty : occupancy
// Revision : 1.0 - initial release
// ============================================================================
module lsq_param_fwd #(
    parameter int DEPTH     = 8,
    parameter int ROB_TAG_W = 5,
    parameter int XLEN      = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    disp_valid,
    input  logic                    disp_is_store,
    input  logic [ROB_TAG_W-1:0]    disp_rob_tag,
    output logic                    disp_ready,
    input  logic                    iss_valid,
    input  logic [ROB_TAG_W-1:0]    iss_rob_tag,
    input  logic [2:0]              iss_func3,
    input  logic [XLEN-1:0]         iss_base,
    input  logic [XLEN-1:0]         iss_imm,
    input  logic [XLEN-1:0]         iss_data,
    input  logic [ROB_TAG_W-1:0]    ld_rob_tag,
    input  logic                    ld_valid,
    output logic                    ld_fwd_valid,
    output logic [XLEN-1:0]         ld_fwd_data,
    output logic                    ld_stall,
    input  logic                    commit_valid,
    input  logic [ROB_TAG_W-1:0]    commit_rob_tag,
    output logic                    mem_wr_valid,
    output logic [XLEN-1:0]         mem_wr_addr,
    output logic [XLEN-1:0]         mem_wr_data,
    output logic [3:0]              mem_wr_be,
    input  logic                    mem_wr_ready,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty
);

    localparam int                 c_IDX_W   = $clog2(DEPTH);
    localparam int                 c_PTR_W   = c_IDX_W + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_PTR_W-1:0] c_FULL    = c_PTR_W'(DEPTH);

    // Byte lanes touched by an access; H keeps only a[1], W ignores a[1:0].
    function automatic logic [3:0] f_byte_en(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   f_byte_en = 4'b0001 << a;
            2'b01:   f_byte_en = 4'b0011 << {a[1], 1'b0};
            default: f_byte_en = 4'b1111;
        endcase
    endfunction

    // Byte offset of the lowest lane touched by an access.
    function automatic logic [1:0] f_lane(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   f_lane = a;
            2'b01:   f_lane = {a[1], 1'b0};
            default: f_lane = 2'b00;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]       r_valid;
    logic [DEPTH-1:0]       r_is_store;
    logic [DEPTH-1:0]       r_issued;
    logic [DEPTH-1:0]       r_committed;
    logic [ROB_TAG_W-1:0]   r_rob_tag [DEPTH];
    logic [XLEN-1:0]        r_addr    [DEPTH];
    logic [XLEN-1:0]        r_data    [DEPTH];
    logic [2:0]             r_func3   [DEPTH];

    logic [c_PTR_W-1:0]     r_head;
    logic [c_PTR_W-1:0]     r_tail;

    logic                   r_mem_wr_valid;
    logic [XLEN-1:0]        r_mem_wr_addr;
    logic [XLEN-1:0]        r_mem_wr_data;
    logic [3:0]             r_mem_wr_be;

    logic [c_IDX_W-1:0]     w_head_idx;
    logic [c_IDX_W-1:0]     w_tail_idx;
    logic [c_PTR_W-1:0]     w_count;
    logic                   w_commit_hit;
    logic                   w_commit_load;
    logic                   w_commit_store;
    logic                   w_wr_done;
    logic                   w_free;
    logic                   w_disp;
    logic                   w_iss_hit;
    logic [c_IDX_W-1:0]     w_iss_idx;

    assign w_head_idx = r_head[c_IDX_W-1:0];
    assign w_tail_idx = r_tail[c_IDX_W-1:0];
    assign w_count    = r_tail - r_head;

    // Only the head can be retiring; a committed store stays at the head
    // until its write handshakes, so at most one write is ever outstanding.
    assign w_commit_hit   = commit_valid && !flush && r_valid[w_head_idx] &&
                            (r_rob_tag[w_head_idx] == commit_rob_tag) &&
                            r_issued[w_head_idx] && !r_committed[w_head_idx];
    assign w_commit_load  = w_commit_hit && !r_is_store[w_head_idx];
    assign w_commit_store = w_commit_hit &&  r_is_store[w_head_idx] && !r_mem_wr_valid;
    assign w_wr_done      = r_mem_wr_valid && mem_wr_ready;
    assign w_free         = w_commit_load || w_wr_done;

    // A slot freed this cycle can be reused by a same-cycle dispatch.
    assign disp_ready = (w_count != c_FULL) || w_free;
    assign w_disp     = disp_valid && disp_ready && !flush;

    always_comb begin
        w_iss_hit = 1'b0;
        w_iss_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && !r_issued[i] && (r_rob_tag[i] == iss_rob_tag)) begin
                w_iss_hit = 1'b1;
                w_iss_idx = c_IDX_W'(i);
            end
        end
        if (!iss_valid || flush) begin
            w_iss_hit = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding lookup
    // ------------------------------------------------------------------
    logic                   w_ld_hit;
    logic [c_IDX_W-1:0]     w_ld_idx;
    logic [c_IDX_W-1:0]     w_ld_age;
    logic [c_IDX_W-1:0]     w_age_i;
    logic [3:0]             w_ld_be;
    logic [3:0]             w_st_be;
    logic                   w_older_unissued;
    logic                   w_st_hit;
    logic [c_IDX_W-1:0]     w_st_idx;
    logic [c_IDX_W-1:0]     w_st_age;
    logic [XLEN-1:0]        w_lane_data;
    logic [XLEN-1:0]        w_shifted;

    always_comb begin
        w_ld_hit = 1'b0;
        w_ld_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && !r_is_store[i] && (r_rob_tag[i] == ld_rob_tag)) begin
                w_ld_hit = 1'b1;
                w_ld_idx = c_IDX_W'(i);
            end
        end

        // Age is distance from head, so ordering survives pointer wrap.
        w_ld_age         = w_ld_idx - w_head_idx;
        w_ld_be          = f_byte_en(r_func3[w_ld_idx], r_addr[w_ld_idx][1:0]);
        w_age_i          = '0;
        w_older_unissued = 1'b0;
        w_st_hit         = 1'b0;
        w_st_idx         = '0;
        w_st_age         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_age_i = c_IDX_W'(i) - w_head_idx;
            if (r_valid[i] && r_is_store[i] && (w_age_i < w_ld_age)) begin
                if (!r_issued[i]) begin
                    w_older_unissued = 1'b1;
                end else if ((r_addr[i][XLEN-1:2] == r_addr[w_ld_idx][XLEN-1:2]) &&
                             ((f_byte_en(r_func3[i], r_addr[i][1:0]) & w_ld_be) != 4'b0000) &&
                             (!w_st_hit || (w_age_i > w_st_age))) begin
                    w_st_hit = 1'b1;
                    w_st_idx = c_IDX_W'(i);
                    w_st_age = w_age_i;
                end
            end
        end

        // Place store bytes in their word lanes, then pull the load's lanes down.
        w_st_be     = f_byte_en(r_func3[w_st_idx], r_addr[w_st_idx][1:0]);
        w_lane_data = r_data[w_st_idx] << {f_lane(r_func3[w_st_idx], r_addr[w_st_idx][1:0]), 3'b000};
        w_shifted   = w_lane_data >> {f_lane(r_func3[w_ld_idx], r_addr[w_ld_idx][1:0]), 3'b000};

        ld_fwd_valid = 1'b0;
        ld_fwd_data  = '0;
        ld_stall     = 1'b0;
        if (ld_valid && w_ld_hit) begin
            if (!r_issued[w_ld_idx] || w_older_unissued) begin
                ld_stall = 1'b1;
            end else if (w_st_hit) begin
                if ((w_st_be & w_ld_be) == w_ld_be) begin
                    ld_fwd_valid = 1'b1;
                    case (r_func3[w_ld_idx])
                        3'b000:  ld_fwd_data = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
                        3'b001:  ld_fwd_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
                        3'b100:  ld_fwd_data = {{(XLEN-8){1'b0}},           w_shifted[7:0]};
                        3'b101:  ld_fwd_data = {{(XLEN-16){1'b0}},          w_shifted[15:0]};
                        default: ld_fwd_data = w_shifted;
                    endcase
                end else begin
                    ld_stall = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_valid        <= '0;
            r_is_store     <= '0;
            r_issued       <= '0;
            r_committed    <= '0;
            r_mem_wr_valid <= 1'b0;
            r_mem_wr_addr  <= '0;
            r_mem_wr_data  <= '0;
            r_mem_wr_be    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rob_tag[i] <= '0;
                r_addr[i]    <= '0;
                r_data[i]    <= '0;
                r_func3[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush && !r_committed[i]) begin
                    r_valid[i] <= 1'b0;
                end
                if (w_free && (c_IDX_W'(i) == w_head_idx)) begin
                    r_valid[i]     <= 1'b0;
                    r_committed[i] <= 1'b0;
                end
                // Dispatch after free: a full queue reuses the slot just freed.
                if (w_disp && (c_IDX_W'(i) == w_tail_idx)) begin
                    r_valid[i]     <= 1'b1;
                    r_is_store[i]  <= disp_is_store;
                    r_rob_tag[i]   <= disp_rob_tag;
                    r_issued[i]    <= 1'b0;
                    r_committed[i] <= 1'b0;
                end
                if (w_iss_hit && (c_IDX_W'(i) == w_iss_idx)) begin
                    r_issued[i] <= 1'b1;
                    r_addr[i]   <= iss_base + iss_imm;
                    r_data[i]   <= iss_data;
                    r_func3[i]  <= iss_func3;
                end
                if (w_commit_store && (c_IDX_W'(i) == w_head_idx)) begin
                    r_committed[i] <= 1'b1;
                end
            end

            if (w_free) begin
                r_head <= r_head + c_PTR_ONE;
            end

            // Only a committed head survives a flush, so tail lands just past it.
            if (flush) begin
                r_tail <= (r_valid[w_head_idx] && r_committed[w_head_idx]) ?
                          r_head + c_PTR_ONE : r_head;
            end else if (w_disp) begin
                r_tail <= r_tail + c_PTR_ONE;
            end

            if (w_commit_store) begin
                r_mem_wr_valid <= 1'b1;
                r_mem_wr_addr  <= {r_addr[w_head_idx][XLEN-1:2], 2'b00};
                r_mem_wr_data  <= r_data[w_head_idx] <<
                                  {f_lane(r_func3[w_head_idx], r_addr[w_head_idx][1:0]), 3'b000};
                r_mem_wr_be    <= f_byte_en(r_func3[w_head_idx], r_addr[w_head_idx][1:0]);
            end else if (w_wr_done) begin
                r_mem_wr_valid <= 1'b0;
            end
        end
    end

    assign mem_wr_valid = r_mem_wr_valid;
    assign mem_wr_addr  = r_mem_wr_addr;
    assign mem_wr_data  = r_mem_wr_data;
    assign mem_wr_be    = r_mem_wr_be;
    assign count        = w_count;
    assign empty        = (w_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_lsq_param_fwd.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsq_param_fwd
// Purpose  : Self-checking bench for lsq_param_fwd. A program-order queue
//            model predicts occupancy, write port and forwarding results
//            from byte-address arithmetic; directed scenarios add literal
//            expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsq_param_fwd;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        disp_valid = 1'b0, disp_is_store = 1'b0;
    logic [4:0]  disp_rob_tag = '0;
    logic        disp_ready;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rob_tag = '0;
    logic [2:0]  iss_func3 = '0;
    logic [31:0] iss_base = '0, iss_imm = '0, iss_data = '0;
    logic [4:0]  ld_rob_tag = '0;
    logic        ld_valid = 1'b0;
    logic        ld_fwd_valid, ld_stall;
    logic [31:0] ld_fwd_data;
    logic        commit_valid = 1'b0;
    logic [4:0]  commit_rob_tag = '0;
    logic        mem_wr_valid;
    logic [31:0] mem_wr_addr, mem_wr_data;
    logic [3:0]  mem_wr_be;
    logic        mem_wr_ready = 1'b1;
    logic        flush = 1'b0;
    logic [3:0]  count;
    logic        empty;

    lsq_param_fwd #(.DEPTH(DEPTH), .ROB_TAG_W(5), .XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .disp_valid(disp_valid), .disp_is_store(disp_is_store),
        .disp_rob_tag(disp_rob_tag), .disp_ready(disp_ready),
        .iss_valid(iss_valid), .iss_rob_tag(iss_rob_tag), .iss_func3(iss_func3),
        .iss_base(iss_base), .iss_imm(iss_imm), .iss_data(iss_data),
        .ld_rob_tag(ld_rob_tag), .ld_valid(ld_valid),
        .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data), .ld_stall(ld_stall),
        .commit_valid(commit_valid), .commit_rob_tag(commit_rob_tag),
        .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_be(mem_wr_be), .mem_wr_ready(mem_wr_ready),
        .flush(flush), .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: queue in program order, index 0 is oldest.
    // ------------------------------------------------------------------
    typedef struct {
        logic        is_store;
        logic [4:0]  tag;
        logic        issued;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  f3;
        logic        committed;
    } ent_t;

    ent_t        mq[$];
    logic        m_wv  = 1'b0;
    logic [31:0] m_wa  = '0, m_wd = '0;
    logic [3:0]  m_wbe = '0;

    function automatic logic [31:0] mstart(input logic [31:0] a, input logic [2:0] f3);
        if (f3[1:0] == 2'b00)      return a;
        else if (f3[1:0] == 2'b01) return a & ~32'h1;
        else                       return a & ~32'h3;
    endfunction

    function automatic int mlen(input logic [2:0] f3);
        if (f3[1:0] == 2'b00)      return 1;
        else if (f3[1:0] == 2'b01) return 2;
        else                       return 4;
    endfunction

    function automatic logic [31:0] mext(input logic [31:0] raw, input logic [2:0] f3);
        case (f3)
            3'b000:  return {{24{raw[7]}}, raw[7:0]};
            3'b001:  return {{16{raw[15]}}, raw[15:0]};
            3'b100:  return {24'h0, raw[7:0]};
            3'b101:  return {16'h0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    function automatic bit m_commit_hit();
        if (!commit_valid || flush || mq.size() == 0) return 1'b0;
        return (mq[0].tag == commit_rob_tag) && mq[0].issued && !mq[0].committed;
    endfunction

    function automatic bit m_dready();
        bit free;
        free = (m_commit_hit() && !mq[0].is_store) || (m_wv && mem_wr_ready);
        return (mq.size() < DEPTH) || free;
    endfunction

    function automatic void mlook(output logic fv, output logic [31:0] fd, output logic st);
        int k;
        longint ls, ll, ss, sl;
        logic [31:0] raw;
        fv = 1'b0; fd = '0; st = 1'b0; k = -1;
        if (!ld_valid) return;
        for (int j = 0; j < mq.size(); j++)
            if (k < 0 && !mq[j].is_store && mq[j].tag == ld_rob_tag) k = j;
        if (k < 0) return;
        if (!mq[k].issued) begin st = 1'b1; return; end
        for (int j = 0; j < k; j++)
            if (mq[j].is_store && !mq[j].issued) begin st = 1'b1; return; end
        ls = mstart(mq[k].addr, mq[k].f3);
        ll = mlen(mq[k].f3);
        for (int j = k - 1; j >= 0; j--) begin
            if (mq[j].is_store) begin
                ss = mstart(mq[j].addr, mq[j].f3);
                sl = mlen(mq[j].f3);
                if (ls < ss + sl && ss < ls + ll) begin
                    if (ls >= ss && ls + ll <= ss + sl) begin
                        raw = '0;
                        for (int b = 0; b < ll; b++)
                            raw[8*b +: 8] = mq[j].data[8*(ls + b - ss) +: 8];
                        fv = 1'b1;
                        fd = mext(raw, mq[k].f3);
                    end else begin
                        st = 1'b1;
                    end
                    return;
                end
            end
        end
    endfunction

    function automatic void mwrite(input ent_t e);
        logic [31:0] s;
        int lane;
        s = mstart(e.addr, e.f3);
        m_wa = s & ~32'h3;
        m_wbe = '0;
        m_wd = '0;
        for (int b = 0; b < mlen(e.f3); b++) begin
            lane = int'(s[1:0]) + b;
            m_wbe[lane] = 1'b1;
            m_wd[8*lane +: 8] = e.data[8*b +: 8];
        end
    endfunction

    function automatic void model_step();
        bit hit, cl, cs, wdone, free, dsp, keep;
        int ii;
        ent_t e;
        wdone = m_wv && mem_wr_ready;
        hit   = m_commit_hit();
        cl    = hit && !mq[0].is_store;
        cs    = hit && mq[0].is_store && !m_wv;
        free  = cl || wdone;
        dsp   = disp_valid && m_dready() && !flush;
        if (iss_valid && !flush) begin
            ii = -1;
            for (int j = 0; j < mq.size(); j++)
                if (ii < 0 && mq[j].tag == iss_rob_tag && !mq[j].issued) ii = j;
            if (ii >= 0) begin
                e = mq[ii];
                e.issued = 1'b1;
                e.addr = iss_base + iss_imm;
                e.data = iss_data;
                e.f3 = iss_func3;
                mq[ii] = e;
            end
        end
        if (cs) begin
            e = mq[0];
            e.committed = 1'b1;
            mq[0] = e;
            m_wv = 1'b1;
            mwrite(e);
        end
        if (wdone) m_wv = 1'b0;
        if (flush) begin
            keep = (mq.size() > 0) && mq[0].committed;
            while (mq.size() > (keep ? 1 : 0)) void'(mq.pop_back());
        end
        if (free) void'(mq.pop_front());
        if (dsp) begin
            e = '{is_store: disp_is_store, tag: disp_rob_tag, issued: 1'b0,
                  addr: '0, data: '0, f3: '0, committed: 1'b0};
            mq.push_back(e);
        end
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_wv = 1'b0; m_wa = '0; m_wd = '0; m_wbe = '0;
        end else begin
            model_step();
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic fv, st;
        logic [31:0] fd;
        if (!reset) begin
            chk("rst_count", 32'(count), 32'd0);
            chk("rst_empty", 32'(empty), 32'd1);
            chk("rst_disp_ready", 32'(disp_ready), 32'd1);
            chk("rst_wr_valid", 32'(mem_wr_valid), 32'd0);
            chk("rst_wr_addr", mem_wr_addr, 32'd0);
            chk("rst_wr_data", mem_wr_data, 32'd0);
            chk("rst_wr_be", 32'(mem_wr_be), 32'd0);
        end else begin
            chk("count", 32'(count), 32'(mq.size()));
            chk("empty", 32'(empty), 32'(mq.size() == 0));
            chk("disp_ready", 32'(disp_ready), 32'(m_dready()));
            chk("wr_valid", 32'(mem_wr_valid), 32'(m_wv));
            if (m_wv) begin
                chk("wr_addr", mem_wr_addr, m_wa);
                chk("wr_data", mem_wr_data, m_wd);
                chk("wr_be", 32'(mem_wr_be), 32'(m_wbe));
            end
            mlook(fv, fd, st);
            chk("ld_fwd_valid", 32'(ld_fwd_valid), 32'(fv));
            chk("ld_fwd_data", ld_fwd_data, fd);
            chk("ld_stall", 32'(ld_stall), 32'(st));
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic st, input logic [4:0] tag);
        disp_valid = 1'b1; disp_is_store = st; disp_rob_tag = tag;
        tick();
        disp_valid = 1'b0;
    endtask

    task automatic iss(input logic [4:0] tag, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] imm, input logic [31:0] data);
        iss_valid = 1'b1; iss_rob_tag = tag; iss_func3 = f3;
        iss_base = base; iss_imm = imm; iss_data = data;
        tick();
        iss_valid = 1'b0;
    endtask

    task automatic cmt(input logic [4:0] tag);
        commit_valid = 1'b1; commit_rob_tag = tag;
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic look(input string name, input logic [4:0] tag, input logic ev,
                        input logic [31:0] ed, input logic es);
        ld_valid = 1'b1; ld_rob_tag = tag;
        #1;
        chk({name, "_fv"}, 32'(ld_fwd_valid), 32'(ev));
        chk({name, "_fd"}, ld_fwd_data, ed);
        chk({name, "_st"}, 32'(ld_stall), 32'(es));
        tick();
        ld_valid = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("lit_rst_count", 32'(count), 32'd0);
        chk("lit_rst_empty", 32'(empty), 32'd1);
        chk("lit_rst_ready", 32'(disp_ready), 32'd1);
        chk("lit_rst_wr_valid", 32'(mem_wr_valid), 32'd0);
        reset = 1'b1;
        tick();

        // Full-word forward, then drain through memory.
        disp(1'b1, 5'd1); disp(1'b0, 5'd2);
        iss(5'd1, 3'b010, 32'h100, 32'h0, 32'h11223344);
        iss(5'd2, 3'b010, 32'hF0, 32'h10, 32'h0);
        look("t1_lw", 5'd2, 1'b1, 32'h11223344, 1'b0);
        cmt(5'd1);
        chk("t1_wr_valid", 32'(mem_wr_valid), 32'd1);
        chk("t1_wr_addr", mem_wr_addr, 32'h100);
        chk("t1_wr_data", mem_wr_data, 32'h11223344);
        chk("t1_wr_be", 32'(mem_wr_be), 32'hF);
        tick();
        cmt(5'd2);
        chk("t1_empty", 32'(empty), 32'd1);

        // Sub-word loads out of a word store, with sign/zero extension.
        disp(1'b1, 5'd3); disp(1'b0, 5'd4); disp(1'b0, 5'd5); disp(1'b0, 5'd6);
        iss(5'd3, 3'b010, 32'h200, 32'h0, 32'h8899AABB);
        iss(5'd4, 3'b000, 32'h200, 32'h3, 32'h0);
        iss(5'd5, 3'b100, 32'h203, 32'h0, 32'h0);
        iss(5'd6, 3'b001, 32'h202, 32'h0, 32'h0);
        look("t2_lb", 5'd4, 1'b1, 32'hFFFFFF88, 1'b0);
        look("t2_lbu", 5'd5, 1'b1, 32'h00000088, 1'b0);
        look("t2_lh", 5'd6, 1'b1, 32'hFFFF8899, 1'b0);
        do_flush();
        chk("t2_flush_empty", 32'(empty), 32'd1);

        // Partial coverage, no overlap, and an older unissued store.
        disp(1'b1, 5'd7); disp(1'b0, 5'd8); disp(1'b0, 5'd9);
        iss(5'd7, 3'b001, 32'h302, 32'h0, 32'h0000BEEF);
        iss(5'd8, 3'b010, 32'h300, 32'h0, 32'h0);
        iss(5'd9, 3'b000, 32'h301, 32'h0, 32'h0);
        look("t3_partial", 5'd8, 1'b0, 32'h0, 1'b1);
        look("t3_nooverlap", 5'd9, 1'b0, 32'h0, 1'b0);
        disp(1'b1, 5'd10); disp(1'b0, 5'd11);
        iss(5'd11, 3'b010, 32'h900, 32'h0, 32'h0);
        look("t3_unissued", 5'd11, 1'b0, 32'h0, 1'b1);
        do_flush();

        // Youngest older store wins; unmatched issue is ignored.
        disp(1'b1, 5'd12); disp(1'b1, 5'd13); disp(1'b0, 5'd14);
        iss(5'd12, 3'b010, 32'h400, 32'h0, 32'h1);
        iss(5'd13, 3'b010, 32'h400, 32'h0, 32'h2);
        iss(5'd14, 3'b010, 32'h400, 32'h0, 32'h0);
        iss(5'd31, 3'b010, 32'h400, 32'h0, 32'h5);
        look("t4_youngest", 5'd14, 1'b1, 32'h2, 1'b0);
        do_flush();

        // Fill, drop while full, then free + dispatch in one cycle.
        for (int i = 0; i < DEPTH; i++) disp(1'b0, 5'(16 + i));
        chk("t5_full_count", 32'(count), 32'd8);
        chk("t5_full_ready", 32'(disp_ready), 32'd0);
        iss(5'd16, 3'b010, 32'h700, 32'h0, 32'h0);
        disp(1'b0, 5'd30);
        chk("t5_drop_count", 32'(count), 32'd8);
        commit_valid = 1'b1; commit_rob_tag = 5'd16;
        disp_valid = 1'b1; disp_is_store = 1'b0; disp_rob_tag = 5'd24;
        #1;
        chk("t5_free_ready", 32'(disp_ready), 32'd1);
        tick();
        commit_valid = 1'b0; disp_valid = 1'b0;
        chk("t5_swap_count", 32'(count), 32'd8);
        do_flush();
        chk("t5_flush_empty", 32'(empty), 32'd1);

        // Back-pressured write survives a flush.
        disp(1'b1, 5'd1); disp(1'b0, 5'd2); disp(1'b0, 5'd3);
        iss(5'd1, 3'b010, 32'h800, 32'h0, 32'hCAFEF00D);
        mem_wr_ready = 1'b0;
        cmt(5'd1);
        chk("t6_wr_addr", mem_wr_addr, 32'h800);
        tick();
        do_flush();
        tick();
        chk("t6_held_count", 32'(count), 32'd1);
        chk("t6_held_valid", 32'(mem_wr_valid), 32'd1);
        chk("t6_held_data", mem_wr_data, 32'hCAFEF00D);
        mem_wr_ready = 1'b1;
        tick();
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_wr_done", 32'(mem_wr_valid), 32'd0);

        // Byte and halfword store lane placement.
        disp(1'b1, 5'd4); disp(1'b1, 5'd5);
        iss(5'd4, 3'b000, 32'h800, 32'h3, 32'h1234565A);
        iss(5'd5, 3'b001, 32'h806, 32'h0, 32'h1234BEEF);
        cmt(5'd4);
        chk("t7_sb_addr", mem_wr_addr, 32'h800);
        chk("t7_sb_be", 32'(mem_wr_be), 32'h8);
        chk("t7_sb_data", mem_wr_data, 32'h5A000000);
        tick();
        cmt(5'd5);
        chk("t7_sh_addr", mem_wr_addr, 32'h804);
        chk("t7_sh_be", 32'(mem_wr_be), 32'hC);
        chk("t7_sh_data", mem_wr_data, 32'hBEEF0000);
        tick();
        chk("t7_empty", 32'(empty), 32'd1);

        // Asynchronous reset drops a pending write at once.
        disp(1'b1, 5'd6);
        iss(5'd6, 3'b010, 32'hA00, 32'h0, 32'h55);
        mem_wr_ready = 1'b0;
        cmt(5'd6);
        chk("t8_pending", 32'(mem_wr_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t8_async_valid", 32'(mem_wr_valid), 32'd0);
        chk("t8_async_count", 32'(count), 32'd0);
        tick(); tick();
        reset = 1'b1;
        mem_wr_ready = 1'b1;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
